// File: rtl/compositor_pkg.sv
// Shared definitions for the two-layer compositor: mode encodings and RGB565 field bounds.
// The latched-config bundle is built from these in layer_compositor, where the widths are known.
package compositor_pkg;

    typedef enum logic [1:0] {
        MODE_PASS    = 2'd0,
        MODE_OVERLAY = 2'd1,
        MODE_CHROMA  = 2'd2,
        MODE_BLEND   = 2'd3
    } mode_t;

    localparam int unsigned RGB_R_HI = 15;
    localparam int unsigned RGB_R_LO = 11;
    localparam int unsigned RGB_G_HI = 10;
    localparam int unsigned RGB_G_LO = 5;
    localparam int unsigned RGB_B_HI = 4;
    localparam int unsigned RGB_B_LO = 0;

endpackage

// File: rtl/compositor_delay.sv
// Width x depth shift register with asynchronous clear, used to align pixel and config data
// with the foreground SRAM read latency.
module compositor_delay
    import compositor_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/layer_compositor.sv
// Pipelined two-layer compositor: fetch address generation, latency alignment and mixing.
// Define LAYER_COMPOSITOR_BLEND_EN to build the 50 % blend for mode 3 (otherwise mode 3 = passthrough).
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int unsigned COLOR_W    = 16,
    parameter int unsigned X_W        = 10,
    parameter int unsigned Y_W        = 9,
    parameter int unsigned FG_LATENCY = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COLOR_W-1:0] BGRGB,
    input  logic [X_W-1:0]     BGX,
    input  logic [Y_W-1:0]     BGY,
    input  logic               pixelEnable,
    output logic [X_W-1:0]     FGX,
    output logic [Y_W-1:0]     FGY,
    input  logic [COLOR_W-1:0] FGRGB,
    output logic [COLOR_W-1:0] pixelOut,
    output logic               pixelOutEnable,
    input  logic [1:0]         mode,
    input  logic [COLOR_W-1:0] chromaKey,
    input  logic [COLOR_W-1:0] chromaMask,
    input  logic [X_W-1:0]     fgOffsetX,
    input  logic [Y_W-1:0]     fgOffsetY,
    input  logic [X_W-1:0]     fgWidth,
    input  logic [Y_W-1:0]     fgHeight
);

    typedef struct packed {
        mode_t              mode;
        logic [COLOR_W-1:0] chroma_key;
        logic [COLOR_W-1:0] chroma_mask;
        logic [X_W-1:0]     off_x;
        logic [Y_W-1:0]     off_y;
        logic [X_W-1:0]     width;
        logic [Y_W-1:0]     height;
    } cfg_t;

    typedef struct packed {
        mode_t              mode;
        logic [COLOR_W-1:0] chroma_key;
        logic [COLOR_W-1:0] chroma_mask;
    } mix_cfg_t;

    typedef struct packed {
        logic [COLOR_W-1:0] bg;
        logic               in_win;
        logic               en;
    } pix_t;

    cfg_t               cfg_in;
    cfg_t               cfg_cur;
    cfg_t               cfg_q;
    logic               frame_start;
    logic [X_W-1:0]     dx;
    logic [Y_W-1:0]     dy;
    logic               in_win;
    pix_t               pix_a;
    pix_t               pix_d;
    mix_cfg_t           mix_a;
    mix_cfg_t           mix_d;
    logic               key_hit;
    logic [COLOR_W-1:0] mixed;

    // A frame-start pixel must already see the new config, so the latch value is bypassed into stage A.
    always_comb begin
        cfg_in.mode        = mode_t'(mode);
        cfg_in.chroma_key  = chromaKey;
        cfg_in.chroma_mask = chromaMask;
        cfg_in.off_x       = fgOffsetX;
        cfg_in.off_y       = fgOffsetY;
        cfg_in.width       = fgWidth;
        cfg_in.height      = fgHeight;

        frame_start = pixelEnable && (BGX == '0) && (BGY == '0);
        cfg_cur     = frame_start ? cfg_in : cfg_q;

        dx     = BGX - cfg_cur.off_x;
        dy     = BGY - cfg_cur.off_y;
        in_win = (BGX >= cfg_cur.off_x) && (dx < cfg_cur.width) &&
                 (BGY >= cfg_cur.off_y) && (dy < cfg_cur.height);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            FGX   <= '0;
            FGY   <= '0;
            cfg_q <= '0;
            pix_a <= '0;
        end else begin
            FGX          <= dx;
            FGY          <= dy;
            cfg_q        <= cfg_cur;
            pix_a.bg     <= BGRGB;
            pix_a.in_win <= in_win;
            pix_a.en     <= pixelEnable;
        end
    end

    always_comb begin
        mix_a.mode        = cfg_q.mode;
        mix_a.chroma_key  = cfg_q.chroma_key;
        mix_a.chroma_mask = cfg_q.chroma_mask;
    end

    compositor_delay #(
        .WIDTH ($bits(pix_t)),
        .DEPTH (FG_LATENCY)
    ) u_pix_delay (
        .clk  (clk),
        .rst  (reset),
        .din  (pix_a),
        .dout (pix_d)
    );

    compositor_delay #(
        .WIDTH ($bits(mix_cfg_t)),
        .DEPTH (FG_LATENCY)
    ) u_cfg_delay (
        .clk  (clk),
        .rst  (reset),
        .din  (mix_a),
        .dout (mix_d)
    );

    assign key_hit = ((FGRGB ^ mix_d.chroma_key) & mix_d.chroma_mask) == '0;

`ifdef LAYER_COMPOSITOR_BLEND_EN
    logic [COLOR_W-1:0] blend_px;

    if (COLOR_W == 16) begin : g_blend_rgb565
        logic [RGB_R_HI-RGB_R_LO+1:0] r_sum;
        logic [RGB_G_HI-RGB_G_LO+1:0] g_sum;
        logic [RGB_B_HI-RGB_B_LO+1:0] b_sum;

        // Each field is summed one bit wider so carries never cross into the neighbouring channel.
        always_comb begin
            r_sum = {1'b0, FGRGB[RGB_R_HI:RGB_R_LO]} + {1'b0, pix_d.bg[RGB_R_HI:RGB_R_LO]};
            g_sum = {1'b0, FGRGB[RGB_G_HI:RGB_G_LO]} + {1'b0, pix_d.bg[RGB_G_HI:RGB_G_LO]};
            b_sum = {1'b0, FGRGB[RGB_B_HI:RGB_B_LO]} + {1'b0, pix_d.bg[RGB_B_HI:RGB_B_LO]};
            blend_px = {r_sum[RGB_R_HI-RGB_R_LO+1:1],
                        g_sum[RGB_G_HI-RGB_G_LO+1:1],
                        b_sum[RGB_B_HI-RGB_B_LO+1:1]};
        end
    end else begin : g_blend_mono
        logic [COLOR_W:0] sum;

        always_comb begin
            sum      = {1'b0, FGRGB} + {1'b0, pix_d.bg};
            blend_px = sum[COLOR_W:1];
        end
    end
`endif

    always_comb begin
        mixed = pix_d.bg;
        if (!pix_d.en) begin
            mixed = '0;
        end else if (pix_d.in_win) begin
            case (mix_d.mode)
                MODE_PASS:    mixed = pix_d.bg;
                MODE_OVERLAY: mixed = FGRGB;
                MODE_CHROMA:  mixed = key_hit ? pix_d.bg : FGRGB;
`ifdef LAYER_COMPOSITOR_BLEND_EN
                MODE_BLEND:   mixed = blend_px;
`else
                MODE_BLEND:   mixed = pix_d.bg;
`endif
                default:      mixed = pix_d.bg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixelOut       <= '0;
            pixelOutEnable <= 1'b0;
        end else begin
            pixelOut       <= mixed;
            pixelOutEnable <= pix_d.en;
        end
    end

endmodule
